// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: shared types and constants for the timer controller.
// Holds the FSM state enum, the timer data width and watchdog sizing.
package timer_ctrl_pkg;

    localparam int TMR_W           = 4;
    localparam int WDOG_CYCLES_DEF = 32;
    localparam int WDOG_W          = $clog2(WDOG_CYCLES_DEF + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ARM,
        RUN,
        FINISH
    } state_e;

endpackage

// File: rtl/timer_ctrl_wdog.sv
// timer_ctrl_wdog: RUN-state timeout counter for timer_ctrl_4bit.
// Ports: clk_i, reset_i (sync, active high), clear_i, inc_i, expire_o.
// expire_o is combinational: high in the CYCLES-th consecutive inc cycle.
module timer_ctrl_wdog
    import timer_ctrl_pkg::*;
#(
    parameter int CYCLES = WDOG_CYCLES_DEF,
    parameter int W      = WDOG_W
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = inc_i && (cnt_q == W'(CYCLES - 1));

endmodule

// File: rtl/timer_ctrl_4bit.sv
// timer_ctrl_4bit: command-driven sequencer for a timer_4bit instance.
// Ports: clk, reset (sync, active high); cmd_valid/cmd_ready handshake with
//   cmd_preset, cmd_mode, cmd_reps; abort; timer side tmr_enable, tmr_load,
//   tmr_mode, tmr_preset, tmr_count (status only), tmr_done; status busy,
//   run_cnt, irq, aborted, wdog_err.
// Optional RUN watchdog enabled by defining TIMER_CTRL_WDOG_EN.
module timer_ctrl_4bit
    import timer_ctrl_pkg::*;
#(
    parameter int REP_W       = 4,
    parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [TMR_W-1:0] cmd_preset,
    input  logic             cmd_mode,
    input  logic [REP_W-1:0] cmd_reps,
    input  logic             abort,
    output logic             tmr_enable,
    output logic             tmr_load,
    output logic             tmr_mode,
    output logic [TMR_W-1:0] tmr_preset,
    input  logic [TMR_W-1:0] tmr_count,
    input  logic             tmr_done,
    output logic             busy,
    output logic [REP_W-1:0] run_cnt,
    output logic             irq,
    output logic             aborted,
    output logic             wdog_err
);

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   preset_q;
    logic               mode_q;
    logic [REP_W-1:0]   reps_q;
    // One extra bit so reps = 2^REP_W - 1 completes without wrapping.
    logic [REP_W:0]     run_cnt_q, run_cnt_d;
    logic               load_q, enable_q, irq_q, aborted_q, wdog_err_q;
    logic               accept, abort_take, wdog_set, wdog_hit;
    logic               unused_status;

    assign cmd_ready = (state_q == IDLE) && !reset;
    assign busy      = (state_q != IDLE);
    assign accept    = cmd_valid && cmd_ready;

`ifdef TIMER_CTRL_WDOG_EN
    timer_ctrl_wdog #(
        .CYCLES (WDOG_CYCLES),
        .W      ($clog2(WDOG_CYCLES + 1))
    ) u_wdog (
        .clk_i    (clk),
        .reset_i  (reset),
        .clear_i  (state_q != RUN),
        .inc_i    (state_q == RUN),
        .expire_o (wdog_hit)
    );
`else
    assign wdog_hit = 1'b0;
`endif

    assign unused_status = ^{tmr_count, WDOG_CYCLES[0]};

    always_comb begin
        state_d    = state_q;
        run_cnt_d  = run_cnt_q;
        abort_take = 1'b0;
        wdog_set   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = LOAD;
                    run_cnt_d = '0;
                end
            end
            LOAD: state_d = ARM;
            ARM:  state_d = RUN;
            RUN: begin
                if (tmr_done) begin
                    run_cnt_d = run_cnt_q + {{REP_W{1'b0}}, 1'b1};
                    // Old count equal to reps means this was the last run.
                    if (run_cnt_q == {1'b0, reps_q}) begin
                        state_d = FINISH;
                    end else begin
                        state_d = LOAD;
                    end
                end else if (wdog_hit) begin
                    state_d    = IDLE;
                    abort_take = 1'b1;
                    wdog_set   = 1'b1;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort overrides everything, including a same-cycle done.
        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            run_cnt_d  = run_cnt_q;
            abort_take = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            preset_q   <= '0;
            mode_q     <= 1'b0;
            reps_q     <= '0;
            run_cnt_q  <= '0;
            load_q     <= 1'b0;
            enable_q   <= 1'b0;
            irq_q      <= 1'b0;
            aborted_q  <= 1'b0;
            wdog_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            load_q    <= (state_d == LOAD);
            enable_q  <= (state_d == RUN);
            irq_q     <= (state_d == FINISH);
            aborted_q <= abort_take;
            if (accept) begin
                preset_q   <= cmd_preset;
                mode_q     <= cmd_mode;
                reps_q     <= cmd_reps;
                wdog_err_q <= 1'b0;
            end else if (wdog_set) begin
                wdog_err_q <= 1'b1;
            end
        end
    end

    assign tmr_load   = load_q;
    assign tmr_enable = enable_q;
    assign tmr_mode   = mode_q;
    assign tmr_preset = preset_q;
    assign run_cnt    = run_cnt_q[REP_W-1:0];
    assign irq        = irq_q;
    assign aborted    = aborted_q;
    assign wdog_err   = wdog_err_q;

endmodule
